// File: rtl/cache_fill_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cache_fill_ctrl
// Request front-end and miss handler for the read-only block cache on the
// ray/BVH fetch path. One request is accepted at a time. The controller probes
// the cache. On a miss it issues a single Avalon-MM read, writes the returned
// word into the cache, and then responds. A memory read that never returns is
// abandoned after TIMEOUT cycles with an error response. The late beat that
// may still arrive afterwards is discarded through the stale flag.
//
// Ports
//   clk, rst               : clock (rising edge), async active-low reset
//   req_valid/ready/addr   : word-read request handshake from the fetch unit
//   rsp_valid/ready/data/err : response handshake; err=1 means timed out, data=0
//   c_en/c_wrt/c_addr/c_wdata : cache strobe (1 cycle), fill when c_wrt=1
//   c_rdata/c_success      : cache lookup result, valid the cycle after c_en
//   avm_*                  : Avalon-MM read master towards external memory
//   hit_cnt/miss_cnt       : wrapping lookup statistics
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL  = 24,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BIT_TOTAL-1:0]  req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SIZE_BLOCK-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  c_en,
  output logic                  c_wrt,
  output logic [BIT_TOTAL-1:0]  c_addr,
  output logic [SIZE_BLOCK-1:0] c_wdata,
  input  logic [SIZE_BLOCK-1:0] c_rdata,
  input  logic                  c_success,
  output logic                  avm_read,
  output logic [BIT_TOTAL-1:0]  avm_address,
  input  logic                  avm_waitrequest,
  input  logic [SIZE_BLOCK-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PROBE    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_FILL     = 3'd5,
    ST_RESP     = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [BIT_TOTAL-1:0]  addr_q, addr_d;
  logic [SIZE_BLOCK-1:0] data_q, data_d;
  logic [SIZE_BLOCK-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  stale_q, stale_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0]      hit_q, hit_d;
  logic [CNT_W-1:0]      miss_q, miss_d;
  // Strobes are registered copies of the next-state decode so that every
  // output comes straight from a flop.
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  c_en_q, c_en_d;
  logic                  c_wrt_q, c_wrt_d;
  logic                  avm_read_q, avm_read_d;

  // Next-state, datapath and strobe decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    stale_d    = stale_q;
    tmr_d      = tmr_q;
    hit_d      = hit_q;
    miss_d     = miss_q;

    // The orphaned beat of an abandoned read clears stale wherever it lands.
    if (avm_readdatavalid && stale_q) begin
      stale_d = 1'b0;
    end else begin
      stale_d = stale_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ST_PROBE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROBE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (c_success) begin
          rsp_data_d = c_rdata;
          hit_d      = hit_q + CNT_W'(1);
          state_d    = ST_RESP;
        end else begin
          miss_d     = miss_q + CNT_W'(1);
          state_d    = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        if (!avm_waitrequest) begin
          tmr_d   = '0;
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_MEM_REQ;
        end
      end
      ST_MEM_WAIT: begin
        if (avm_readdatavalid && !stale_q) begin
          data_d  = avm_readdata;
          state_d = ST_FILL;
        end else if (tmr_q == TMR_LAST) begin
          // Give up. The beat may still come later, so mark it as stale.
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          stale_d    = 1'b1;
          state_d    = ST_RESP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_FILL: begin
        rsp_data_d = data_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    c_en_d      = (state_d == ST_PROBE) || (state_d == ST_FILL);
    c_wrt_d     = (state_d == ST_FILL);
    avm_read_d  = (state_d == ST_MEM_REQ);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stale_q     <= 1'b0;
      tmr_q       <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      c_en_q      <= 1'b0;
      c_wrt_q     <= 1'b0;
      avm_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      stale_q     <= stale_d;
      tmr_q       <= tmr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      c_en_q      <= c_en_d;
      c_wrt_q     <= c_wrt_d;
      avm_read_q  <= avm_read_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign c_en        = c_en_q;
  assign c_wrt       = c_wrt_q;
  assign c_addr      = addr_q;
  assign c_wdata     = data_q;
  assign avm_read    = avm_read_q;
  assign avm_address = addr_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
// Bench for cache_fill_ctrl. It emulates the registered cache and an Avalon
// memory with programmable stall, latency and silence. Each request is checked
// against a request-level reference model: a shadow cache, expected counters
// and an expected stale flag.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

  localparam int SB = 32;
  localparam int AW = 24;
  localparam int TO = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [AW-1:0] req_addr, c_addr, avm_address;
  logic [SB-1:0] rsp_data, c_wdata, c_rdata, avm_readdata;
  logic          c_en, c_wrt, c_success, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.SIZE_BLOCK(SB), .BIT_TOTAL(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .c_en(c_en), .c_wrt(c_wrt), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_success(c_success),
    .avm_read(avm_read), .avm_address(avm_address), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Backing-store contents of external memory
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (a)
      24'h000003: return 32'h0000_000A;
      24'h000040: return 32'h0000_0002;
      24'h000100: return 32'h0000_0008;
      default:    return ({8'h00, a} * 32'h9E37_79B1) + 32'h1234_5678;
    endcase
  endfunction

  // ---------------- cache emulation (registered lookup) + fill monitor -------
  logic [31:0] cache_mem [int];
  int          fill_cnt = 0;
  logic [23:0] last_fill_addr = 24'h0;
  logic [31:0] last_fill_data = 32'h0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_mem.delete();
      c_success <= 1'b0;
      c_rdata   <= 32'h0;
    end else begin
      c_success <= 1'b0;
      if (c_en && !c_wrt) begin
        if (cache_mem.exists(int'(c_addr))) begin
          c_success <= 1'b1;
          c_rdata   <= cache_mem[int'(c_addr)];
        end else begin
          c_rdata   <= $urandom;
        end
      end
      if (c_en && c_wrt) begin
        cache_mem[int'(c_addr)] = c_wdata;
        fill_cnt       <= fill_cnt + 1;
        last_fill_addr <= c_addr;
        last_fill_data <= c_wdata;
      end
    end
  end

  // ---------------- Avalon memory emulation + command monitor ----------------
  int          cyc = 0;
  int          ws_cfg = 0;
  int          lat_cfg = 0;
  int          stall_cnt = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [23:0] pend_addr = 24'h0;
  logic        mem_rdv = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        late_rdv = 1'b0;
  logic [31:0] late_data = 32'h0;
  int          cmd_cnt = 0;
  int          acc_cyc = 0;
  int          rdv_set_cyc = 0;
  int          rd_run = 0;
  int          last_rd_run = 0;
  bit          addr_unstable = 1'b0;
  logic [23:0] rd_addr0 = 24'h0;
  logic [23:0] acc_addr = 24'h0;

  assign avm_waitrequest   = avm_read && (stall_cnt < ws_cfg);
  assign avm_readdatavalid = mem_rdv | late_rdv;
  assign avm_readdata      = late_rdv ? late_data : mem_rdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 0;
      pend      <= 1'b0;
      mem_rdv   <= 1'b0;
      rd_run    <= 0;
    end else begin
      cyc     <= cyc + 1;
      mem_rdv <= 1'b0;
      if (avm_read) begin
        if (rd_run == 0) rd_addr0 <= avm_address;
        else if (avm_address != rd_addr0) addr_unstable <= 1'b1;
        if (avm_waitrequest) begin
          stall_cnt <= stall_cnt + 1;
          rd_run    <= rd_run + 1;
        end else begin
          stall_cnt   <= 0;
          rd_run      <= 0;
          last_rd_run <= rd_run + 1;
          cmd_cnt     <= cmd_cnt + 1;
          acc_cyc     <= cyc;
          acc_addr    <= avm_address;
          if (lat_cfg >= 0) begin
            pend      <= 1'b1;
            pend_cnt  <= lat_cfg;
            pend_addr <= avm_address;
          end
        end
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_rdv     <= 1'b1;
          mem_rdata   <= mem_word(pend_addr);
          pend        <= 1'b0;
          rdv_set_cyc <= cyc;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
    end
  end

  // ---------------- request-level reference model ----------------------------
  logic [31:0] ref_cache [int];
  int          ref_hit = 0;
  int          ref_miss = 0;
  bit          ref_stale = 1'b0;

  // One complete request. lat<0 makes memory silent; poke drives a competing
  // req_valid while the response is held back.
  task automatic do_req(input logic [23:0] a, input int ws, input int lat,
                        input int hold, input bit poke);
    bit          exp_hit, exp_err;
    logic [31:0] exp_data;
    int          f0, c0, edges, exp_cmds, exp_fills;
    exp_hit = ref_cache.exists(int'(a));
    if (exp_hit) begin
      exp_data = ref_cache[int'(a)];
      exp_err  = 1'b0;
    end else if (lat < 0 || ref_stale) begin
      exp_data = 32'h0;          // silent memory, or the only beat is eaten as stale
      exp_err  = 1'b1;
    end else begin
      exp_data = mem_word(a);
      exp_err  = 1'b0;
    end
    exp_cmds  = exp_hit ? 0 : 1;
    exp_fills = (exp_hit || exp_err) ? 0 : 1;
    ws_cfg  = ws;
    lat_cfg = lat;
    f0 = fill_cnt;
    c0 = cmd_cnt;

    check_eq("req_ready_idle", 64'(req_ready), 64'(1));
    req_addr  = a;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 0;
    while (!rsp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("rsp_arrives", 64'(rsp_valid), 64'(1));
    if (exp_hit)      check_eq("hit_latency", 64'(edges), 64'(2));
    else if (exp_err) check_eq("timeout_len", 64'(cyc - 1 - acc_cyc), 64'(TO));
    else              check_eq("miss_latency", 64'(cyc - 1 - rdv_set_cyc), 64'(2));

    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_addr  = a ^ 24'h000001;
        req_valid = 1'b1;
      end
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(rsp_valid), 64'(1));
      check_eq("hold_data", 64'(rsp_data), 64'(exp_data));
      check_eq("hold_err", 64'(rsp_err), 64'(exp_err));
      check_eq("hold_req_ready", 64'(req_ready), 64'(0));
    end
    req_valid = 1'b0;
    check_eq("rsp_data", 64'(rsp_data), 64'(exp_data));
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("consumed_valid", 64'(rsp_valid), 64'(0));
    check_eq("consumed_err", 64'(rsp_err), 64'(0));
    check_eq("back_to_idle", 64'(req_ready), 64'(1));

    if (exp_hit) begin
      ref_hit++;
    end else begin
      ref_miss++;
      ref_stale = exp_err;
      if (!exp_err) ref_cache[int'(a)] = exp_data;
    end
    check_eq("hit_cnt", 64'(hit_cnt), 64'(ref_hit));
    check_eq("miss_cnt", 64'(miss_cnt), 64'(ref_miss));
    check_eq("avm_cmds", 64'(cmd_cnt - c0), 64'(exp_cmds));
    check_eq("fill_pulses", 64'(fill_cnt - f0), 64'(exp_fills));
    check_eq("avm_addr_stable", 64'(addr_unstable), 64'(0));
    if (!exp_hit) begin
      check_eq("avm_address", 64'(acc_addr), 64'(a));
      check_eq("avm_read_cycles", 64'(last_rd_run), 64'(ws + 1));
    end
    if (exp_fills == 1) begin
      check_eq("fill_addr", 64'(last_fill_addr), 64'(a));
      check_eq("fill_data", 64'(last_fill_data), 64'(exp_data));
    end
  endtask

  // A beat of data that no request is waiting for
  task automatic late_beat(input logic [31:0] d);
    late_data = d;
    late_rdv  = 1'b1;
    @(posedge clk); #1;
    late_rdv  = 1'b0;
    ref_stale = 1'b0;
  endtask

  initial begin
    int c0;
    req_valid = 1'b0;
    req_addr  = 24'h0;
    rsp_ready = 1'b0;
    rst       = 1'b0;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("reset_flags", 64'({req_ready, rsp_valid, c_en, avm_read, rsp_err}), 64'(5'b10000));
      check_eq("reset_counters", 64'({hit_cnt, miss_cnt}), 64'(0));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("post_reset_ready", 64'(req_ready), 64'(1));

    // Cold miss, then a hit on the same word
    do_req(24'h000003, 0, 2, 0, 1'b0);
    do_req(24'h000003, 0, 2, 0, 1'b0);
    // Miss with a 5-cycle waitrequest stall
    do_req(24'h000040, 5, 1, 0, 1'b0);
    // Hit with response back-pressure and a competing request
    do_req(24'h000040, 0, 0, 4, 1'b1);
    // Silent memory: timeout, late beat discarded, next miss clean
    do_req(24'h000080, 0, -1, 0, 1'b0);
    late_beat(32'h0000_0055);
    do_req(24'h000100, 0, 1, 0, 1'b0);
    // Timeout followed by a miss whose only beat is eaten as stale
    do_req(24'h000081, 0, -1, 0, 1'b0);
    do_req(24'h000082, 0, 2, 1, 1'b0);
    late_beat(32'h0000_0077);
    do_req(24'h000082, 1, 3, 0, 1'b0);

    // Randomized traffic over a small address pool so hits and misses mix
    for (int n = 0; n < 60; n++) begin
      do_req(24'h001000 + 24'($urandom_range(0, 15)) * 24'h000010,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // Reset pulled asynchronously while waiting on memory
    ws_cfg    = 0;
    lat_cfg   = -1;
    c0        = cmd_cnt;
    req_addr  = 24'h000300;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("in_mem_wait_cmd", 64'(cmd_cnt - c0), 64'(1));
    check_eq("in_mem_wait_flags", 64'({req_ready, rsp_valid, avm_read}), 64'(3'b000));
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_reset_flags", 64'({req_ready, rsp_valid, c_en, c_wrt, avm_read, rsp_err}), 64'(6'b100000));
    check_eq("async_reset_counters", 64'({hit_cnt, miss_cnt}), 64'(0));
    check_eq("async_reset_data", 64'(rsp_data), 64'(0));
    ref_cache.delete();
    ref_hit   = 0;
    ref_miss  = 0;
    ref_stale = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_req(24'h000003, 0, 2, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Request front-end and miss handler for the read-only block cache (`cache_ro`) used by the ray/BVH fetch path.
- Accepts word-read requests from the fetch unit over a valid/ready handshake.
- Probes the cache. On a miss, issues one Avalon-MM read to external memory, writes the returned word into the cache, then returns it to the requester.
- Keeps hit/miss counters.
- Handles memory timeouts.

Parameters:
- SIZE_BLOCK, 32, data word width in bits (matches cache block size).
- BIT_TOTAL, 24, word-address width; same address space as the cache.
- TIMEOUT, 256, max cycles in MEM_WAIT before aborting a miss; must be >= 2.
- CNT_W, 32, width of the hit/miss counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low: asserted when 0.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  BIT_TOTAL  word address of the request.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_data  out  SIZE_BLOCK  returned word.
- rsp_err  out  1  response aborted by timeout; rsp_data is 0.
- c_en  out  1  cache access strobe.
- c_wrt  out  1  cache write (fill) when 1, lookup when 0.
- c_addr  out  BIT_TOTAL  cache address.
- c_wdata  out  SIZE_BLOCK  fill data.
- c_rdata  in  SIZE_BLOCK  cache read data, registered.
- c_success  in  1  cache hit flag, registered.
- avm_read  out  1  Avalon read command.
- avm_address  out  BIT_TOTAL  Avalon word address.
- avm_waitrequest  in  1  Avalon stall.
- avm_readdata  in  SIZE_BLOCK  Avalon read data.
- avm_readdatavalid  in  1  Avalon read data valid.
- hit_cnt  out  CNT_W  lookups that hit.
- miss_cnt  out  CNT_W  lookups that missed.

Behaviour:

Reset (rst=0, immediate, asynchronous):
- state=IDLE.
- All outputs 0, except req_ready=1.
- Counters 0, stale flag 0.

Cache timing contract:
- c_en is a 1-cycle strobe.
- c_success/c_rdata are valid in the cycle after the edge that samples c_en.

States:
- IDLE: req_ready=1. On req_valid, latch req_addr → PROBE.
- PROBE: c_en=1, c_wrt=0, c_addr=latched address → CHECK.
- CHECK: sample c_success.
  - Hit: rsp_data<=c_rdata, hit_cnt+1 → RESP.
  - Miss: miss_cnt+1 → MEM_REQ.
- MEM_REQ: avm_read=1, avm_address=latched address, held stable while avm_waitrequest=1. At the edge with avm_waitrequest=0 → MEM_WAIT, timer cleared.
- MEM_WAIT: timer increments each cycle.
  - avm_readdatavalid=1 with stale=0: latch avm_readdata → FILL.
  - Timer reaches TIMEOUT-1 with no valid data: rsp_err<=1, rsp_data<=0, stale<=1 → RESP; no fill.
- FILL: c_en=1, c_wrt=1, c_addr=latched address, c_wdata=latched data. Then rsp_data<=latched data → RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_err stable until the rsp_valid&&rsp_ready edge → IDLE, rsp_err cleared.

Handshake rules:
- req_ready is 1 only in IDLE; exactly one outstanding request at a time.
- Responses are in order.

Stale data:
- Any avm_readdatavalid while stale=1 is discarded and clears stale.
- avm_readdatavalid in any state other than MEM_WAIT is ignored, apart from clearing stale.
- A MEM_WAIT entered with stale=1 discards the first valid beat.

Latency (accept edge = E0):
- Hit: rsp_valid=1 after E2.
- Miss: rsp_valid=1 two edges after the readdatavalid edge.

Output rules:
- Counters wrap at 2^CNT_W.
- c_en is never asserted outside PROBE and FILL.
- avm_read is never asserted outside MEM_REQ.

Reset mid-operation: abandons the transaction with no response and no fill; a read already issued to memory is not tracked.

Test Plan:
1. Hold rst=0 for 5 cycles, then release → req_ready=1; rsp_valid, c_en, avm_read, hit_cnt, miss_cnt all 0 throughout reset.
2. Request addr 0x000003 on a cold cache; memory returns 0x0000000A after 3 cycles:
   - one avm_read with avm_address=3;
   - fill pulse c_wrt=1, c_wdata=0xA;
   - rsp_data=0xA, rsp_err=0, miss_cnt=1.
   - Repeat addr 3 → no avm_read, rsp_valid after E2 with 0xA, hit_cnt=1.
3. Miss to 0x000040 with avm_waitrequest held 5 cycles → avm_read and avm_address=0x40 stable all 6 cycles; exactly one command; rsp_data equals memory word 0x2.
4. Hit response with rsp_ready low 4 cycles → rsp_valid, rsp_data, rsp_err stable; req_ready=0 until the consuming edge; a req_valid pulse meanwhile is not accepted.
5. TIMEOUT=16, memory silent on miss to 0x000080:
   - after 16 MEM_WAIT cycles, rsp_err=1, rsp_data=0; no c_wrt pulse.
   - Late readdatavalid with 0x55 is discarded.
   - Next miss to 0x000100 returning 0x8 → rsp_data=0x8, rsp_err=0.
6. Pull rst low during MEM_WAIT → outputs clear that cycle with no clock edge needed; after release, request 0x000003 is handled as a fresh miss.
